// File: rtl/logic_shift_unit_32_pkg.sv
// Shared definitions for the 32-bit logic/shift execution unit.
//   - operation encodings, FSM state encodings, shifter step modes
//   - latched request payload struct
//   - datapath / shift-amount widths
package logic_shift_unit_32_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned SHAMT_WIDTH = 5;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOR  = 3'd2,
    OP_INV  = 3'd3,
    OP_SLL  = 3'd4,
    OP_SRL  = 3'd5,
    OP_SRA  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EXEC  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_e;

  // Operands captured on the START handshake.
  typedef struct packed {
    op_e                    opr;
    logic [DATA_WIDTH-1:0]  a;
    logic [DATA_WIDTH-1:0]  b;
    logic [SHAMT_WIDTH-1:0] shamt;
  } op_req_t;

  // Map a shift opcode onto the single-bit shifter mode.
  function automatic shift_mode_e shift_mode_of(input op_e op);
    case (op)
      OP_SRL:  return SH_SRL;
      OP_SRA:  return SH_SRA;
      default: return SH_SLL;
    endcase
  endfunction

endpackage

// File: rtl/logic_shift_unit_32_if.sv
// Request/result bus of the logic/shift unit.
//   master: start, opr, a, b, shamt out; y, busy, done, zero in
//   slave : the reverse (the execution unit side)
interface logic_shift_unit_32_if;
  import logic_shift_unit_32_pkg::*;

  logic                   start;
  op_e                    opr;
  logic [DATA_WIDTH-1:0]  a;
  logic [DATA_WIDTH-1:0]  b;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  y;
  logic                   busy;
  logic                   done;
  logic                   zero;

  modport master (
    output start, opr, a, b, shamt,
    input  y, busy, done, zero
  );

  modport slave (
    input  start, opr, a, b, shamt,
    output y, busy, done, zero
  );

endinterface

// File: rtl/AND32_2x1.sv
// 32-bit two-input AND gate array.
//   a, b : operands
//   y    : a & b
module AND32_2x1 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a & b;
endmodule

// File: rtl/INV32_1x1.sv
// 32-bit inverter array.
//   a : operand
//   y : ~a
module INV32_1x1 (
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = ~a;
endmodule

// File: rtl/NOR32_2x1.sv
// 32-bit two-input NOR gate array.
//   a, b : operands
//   y    : ~(a | b)
module NOR32_2x1 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = ~(a | b);
endmodule

// File: rtl/OR32_2x1.sv
// 32-bit two-input OR gate array.
//   a, b : operands
//   y    : a | b
module OR32_2x1 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a | b;
endmodule

// File: rtl/shift_step_32.sv
// Combinational single-bit shifter used once per SHIFT cycle.
//   d    : word to shift
//   mode : SH_SLL (0 in at LSB), SH_SRL (0 in at MSB), SH_SRA (MSB replicated)
//   q    : word shifted by one bit
module shift_step_32
  import logic_shift_unit_32_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] d,
  input  shift_mode_e           mode,
  output logic [DATA_WIDTH-1:0] q
);

  always_comb begin
    q = d;
    case (mode)
      SH_SLL:  q = {d[DATA_WIDTH-2:0], 1'b0};
      SH_SRL:  q = {1'b0, d[DATA_WIDTH-1:1]};
      SH_SRA:  q = {d[DATA_WIDTH-1], d[DATA_WIDTH-1:1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/logic_shift_unit_32.sv
// Multi-cycle 32-bit logic/shift execution unit.
// Operands are latched on START in IDLE; logic ops finish in one EXEC cycle,
// shifts iterate one bit per SHIFT cycle. The result register y updates only
// on the edge entering DONE, where a one-cycle done pulse is raised.
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : slave side of logic_shift_unit_32_if
//          (start/opr/a/b/shamt in; y/busy/done registered out; zero = (y == 0))
module logic_shift_unit_32
  import logic_shift_unit_32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  logic_shift_unit_32_if.slave  bus
);

  state_e                 state_q, state_d;
  op_req_t                req_q, req_d;
  logic [DATA_WIDTH-1:0]  work_q, work_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  y_q, y_d;
  logic                   busy_q;
  logic                   done_q;

  logic [DATA_WIDTH-1:0]  and_y, or_y, nor_y, inv_y;
  logic [DATA_WIDTH-1:0]  logic_y;
  logic [DATA_WIDTH-1:0]  step_q;
  shift_mode_e            step_mode;

  // Gate arrays on the latched operands.
  AND32_2x1 u_and (.a(req_q.a), .b(req_q.b), .y(and_y));
  OR32_2x1  u_or  (.a(req_q.a), .b(req_q.b), .y(or_y));
  NOR32_2x1 u_nor (.a(req_q.a), .b(req_q.b), .y(nor_y));
  INV32_1x1 u_inv (.a(req_q.a), .y(inv_y));

  // 4:1 result select for ops 0-3 (low two opcode bits).
  always_comb begin
    logic_y = and_y;
    case (req_q.opr[1:0])
      2'd0:    logic_y = and_y;
      2'd1:    logic_y = or_y;
      2'd2:    logic_y = nor_y;
      default: logic_y = inv_y;
    endcase
  end

  assign step_mode = shift_mode_of(req_q.opr);

  shift_step_32 u_step (
    .d    (work_q),
    .mode (step_mode),
    .q    (step_q)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    y_d     = y_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          req_d   = '{opr: bus.opr, a: bus.a, b: bus.b, shamt: bus.shamt};
          state_d = EXEC;
        end
      end

      EXEC: begin
        case (req_q.opr)
          OP_AND, OP_OR, OP_NOR, OP_INV: begin
            y_d     = logic_y;
            state_d = DONE;
          end
          OP_SLL, OP_SRL, OP_SRA: begin
            if (req_q.shamt == '0) begin
              y_d     = req_q.a;
              state_d = DONE;
            end else begin
              work_d  = req_q.a;
              cnt_d   = req_q.shamt;
              state_d = SHIFT;
            end
          end
          default: begin
            y_d     = '0;
            state_d = DONE;
          end
        endcase
      end

      SHIFT: begin
        work_d = step_q;
        cnt_d  = cnt_q - SHAMT_WIDTH'(1);
        // Last step: the shifted word goes straight into the result register.
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          y_d     = step_q;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.zero = (y_q == '0);

endmodule

// File: tb/tb_logic_shift_unit_32.sv
// Directed self-checking bench for logic_shift_unit_32.
module tb_logic_shift_unit_32;
  import logic_shift_unit_32_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic_shift_unit_32_if bus_if ();

  logic_shift_unit_32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait (bounded) for done. lat counts edges from the
  // START edge (=1) up to the edge that raised done; busy_cycles counts
  // cycles with busy high up to and including the done cycle.
  task automatic run_op(input op_e opr, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] shamt, output int lat, output int busy_cycles);
    @(negedge clk);
    bus_if.opr   = opr;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.shamt = shamt;
    bus_if.start = 1'b1;
    @(posedge clk);
    lat         = 1;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      if (bus_if.busy) busy_cycles++;
      if (bus_if.done) break;
      @(posedge clk);
      lat++;
    end
  endtask

  // One cycle after done: pulse gone, unit idle, result held.
  task automatic check_after_done(input string tag, input logic [31:0] y_exp);
    @(negedge clk);
    check({tag, "_done_low"}, 32'(bus_if.done), 32'd0);
    check({tag, "_idle"},     32'(bus_if.busy), 32'd0);
    check({tag, "_y_hold"},   bus_if.y, y_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          bcyc;
    int          dones;
    int          first_done;
    logic [31:0] y_cap;

    rst          = 1'b0;
    bus_if.start = 1'b0;
    bus_if.opr   = OP_AND;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.shamt = '0;

    // Async reset mid-cycle, no clock edge involved.
    #2 rst = 1'b1;
    #1;
    check("rst_y",    bus_if.y, 32'h0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_zero", 32'(bus_if.zero), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Logic ops.
    run_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, lat, bcyc);
    check("and_y",    bus_if.y, 32'hF000_F000);
    check("and_lat",  32'(lat), 32'd2);
    check("and_busy", 32'(bcyc), 32'd2);
    check("and_zero", 32'(bus_if.zero), 32'd0);
    check_after_done("and", 32'hF000_F000);

    run_op(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, lat, bcyc);
    check("or_y",   bus_if.y, 32'hFFF0_FFF0);
    check("or_lat", 32'(lat), 32'd2);

    run_op(OP_RSVD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, lat, bcyc);
    check("rsvd_y",    bus_if.y, 32'h0);
    check("rsvd_lat",  32'(lat), 32'd2);
    check("rsvd_zero", 32'(bus_if.zero), 32'd1);

    run_op(OP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, lat, bcyc);
    check("nor_y",   bus_if.y, 32'h000F_000F);
    check("nor_lat", 32'(lat), 32'd2);

    run_op(OP_INV, 32'hFFFF_FFFF, 32'h1234_5678, 5'd0, lat, bcyc);
    check("inv_y",    bus_if.y, 32'h0);
    check("inv_zero", 32'(bus_if.zero), 32'd1);
    check_after_done("inv", 32'h0);

    // Longest shifts.
    run_op(OP_SRA, 32'h8000_0000, 32'h0, 5'd31, lat, bcyc);
    check("sra31_y",    bus_if.y, 32'hFFFF_FFFF);
    check("sra31_lat",  32'(lat), 32'd33);
    check("sra31_busy", 32'(bcyc), 32'd33);
    check_after_done("sra31", 32'hFFFF_FFFF);

    run_op(OP_SRL, 32'h8000_0000, 32'h0, 5'd31, lat, bcyc);
    check("srl31_y",   bus_if.y, 32'h0000_0001);
    check("srl31_lat", 32'(lat), 32'd33);

    // Zero and short shift amounts.
    run_op(OP_SLL, 32'h0000_0001, 32'h0, 5'd0, lat, bcyc);
    check("sll0_y",   bus_if.y, 32'h0000_0001);
    check("sll0_lat", 32'(lat), 32'd2);

    run_op(OP_SLL, 32'h0000_0001, 32'h0, 5'd4, lat, bcyc);
    check("sll4_y",   bus_if.y, 32'h0000_0010);
    check("sll4_lat", 32'(lat), 32'd6);

    run_op(OP_SRA, 32'h7000_0000, 32'h0, 5'd4, lat, bcyc);
    check("sra4_pos_y", bus_if.y, 32'h0700_0000);

    // START pulsed and operands churned while busy.
    @(negedge clk);
    bus_if.opr   = OP_SLL;
    bus_if.a     = 32'h0000_00A5;
    bus_if.b     = 32'h0;
    bus_if.shamt = 5'd8;
    bus_if.start = 1'b1;
    @(posedge clk);
    lat        = 1;
    dones      = 0;
    first_done = 0;
    y_cap      = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.done) begin
        dones++;
        if (first_done == 0) begin
          first_done = lat;
          y_cap      = bus_if.y;
        end
      end
      if (bus_if.busy) begin
        bus_if.start = 1'b1;
        bus_if.opr   = op_e'($urandom_range(0, 7));
        bus_if.a     = $urandom;
        bus_if.b     = $urandom;
        bus_if.shamt = 5'($urandom);
      end else begin
        bus_if.start = 1'b0;
      end
      @(posedge clk);
      lat++;
    end
    bus_if.start = 1'b0;
    @(negedge clk);
    check("churn_dones",  32'(dones), 32'd1);
    check("churn_lat",    32'(first_done), 32'd10);
    check("churn_y",      y_cap, 32'h0000_A500);
    check("churn_y_hold", bus_if.y, 32'h0000_A500);
    check("churn_idle",   32'(bus_if.busy), 32'd0);

    // Reset in the middle of a shift aborts it.
    @(negedge clk);
    bus_if.opr   = OP_SRL;
    bus_if.a     = 32'h1234_5678;
    bus_if.shamt = 5'd20;
    bus_if.start = 1'b1;
    @(posedge clk);
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      if (bus_if.done) dones++;
    end
    check("abort_busy_before", 32'(bus_if.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_y",    bus_if.y, 32'h0);
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    check("abort_done", 32'(bus_if.done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_if.done) dones++;
    end
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus_if.done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_idle",    32'(bus_if.busy), 32'd0);
    check("abort_y_hold",  bus_if.y, 32'h0);

    run_op(OP_SRL, 32'hF000_0000, 32'h0, 5'd20, lat, bcyc);
    check("post_rst_y",   bus_if.y, 32'h0000_0F00);
    check("post_rst_lat", 32'(lat), 32'd22);
    check_after_done("post_rst", 32'h0000_0F00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
